mdu_iterative: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/mdu_iterative_pkg.sv | 26 ++
 rtl/mdu_div_step.sv | 27 ++
 rtl/mdu_iterative.sv | 203 ++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mdu_op_e    : operation codes presented on the op port
//   mdu_state_e : sequencer states
//   mdu_cnt_width(): step counter width for a given operand width
package mdu_iterative_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_DIV0 = 3'd3,
        ST_FIX  = 3'd4
    } mdu_state_e;

    function automatic int unsigned mdu_cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step (combinational).
//   rem          in  WIDTH+1  partial remainder from the previous step
//   divisor      in  WIDTH    divisor magnitude
//   dividend_bit in  1        next dividend bit, MSB first
//   new_rem      out WIDTH+1  partial remainder after this step
//   q_bit        out 1        quotient bit produced by this step
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH:0]   new_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    // A restored remainder is always below the divisor, so its MSB is zero
    // and dropping it on the shift loses nothing.
    assign w_shift = {rem[WIDTH-1:0], dividend_bit};
    assign w_diff  = {1'b0, w_shift} - {2'b00, divisor};
    assign q_bit   = ~w_diff[WIDTH+1];
    assign new_rem = q_bit ? w_diff[WIDTH:0] : w_shift;

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Signed operands are reduced to magnitudes, an unsigned shift-add multiplier
// (MUL_BPC bits per cycle) or restoring divider (1 bit per cycle) runs, and a
// final FIX cycle applies the result signs.
//   clk, rst (async, active-high)
//   start, op, opa, opb : issue an operation (sampled only while idle)
//   cancel              : abort the operation in flight, drop a same-cycle start
//   hi_wen, lo_wen, wdata : MTHI/MTLO writes, honoured only while idle
//   busy  : operation in flight (pipeline stall source)
//   done  : one-cycle pulse, HI/LO hold the new result
//   hi, lo: architectural HI/LO registers
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_BPC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W     = mdu_cnt_width(WIDTH);
    localparam int unsigned MUL_STEPS = WIDTH / MUL_BPC;
    localparam int unsigned DIV_STEPS = WIDTH;

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // MUL: {partial product, multiplier}; DIV: low half = dividend/quotient
    logic [WIDTH-1:0]   r_mcand;   // multiplicand or divisor magnitude
    logic [WIDTH:0]     r_rem;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    mdu_op_e            w_op;
    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH+MUL_BPC-1:0] w_pp;
    logic [WIDTH+MUL_BPC-1:0] w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_rem;
    logic               w_div_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_op     = mdu_op_e'(op);
    assign w_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
    assign w_neg_a  = w_signed & opa[WIDTH-1];
    assign w_neg_b  = w_signed & opb[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -opa : opa;
    assign w_mag_b  = w_neg_b ? -opb : opb;

    // Multiply step: add multiplicand * (next MUL_BPC multiplier bits) into the
    // upper half, then shift the whole accumulator right. The upper half stays
    // below 2^WIDTH after the shift, so WIDTH+MUL_BPC bits hold the sum.
    always_comb begin
        w_pp = '0;
        for (int unsigned k = 0; k < MUL_BPC; k++) begin
            if (r_acc[k]) begin
                w_pp = w_pp + ({{MUL_BPC{1'b0}}, r_mcand} << k);
            end
        end
    end

    assign w_sum      = {{MUL_BPC{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:MUL_BPC]};

    mdu_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem          (r_rem),
        .divisor      (r_mcand),
        .dividend_bit (r_acc[WIDTH-1]),
        .new_rem      (w_div_rem),
        .q_bit        (w_div_q)
    );

    assign w_prod = r_neg_lo ? -r_acc : r_acc;

    always_comb begin
        if (r_is_div) begin
            w_fix_lo = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_hi ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        end else begin
            w_fix_lo = w_prod[WIDTH-1:0];
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (cancel) begin
                // Abort wins over everything except an idle-time HI/LO write.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
                if (!r_busy) begin
                    if (hi_wen) r_hi <= wdata;
                    if (lo_wen) r_lo <= wdata;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (hi_wen) r_hi <= wdata;
                        if (lo_wen) r_lo <= wdata;
                        if (start) begin
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_rem    <= '0;
                            r_is_div <= op[1];
                            r_neg_lo <= w_neg_a ^ w_neg_b;
                            r_neg_hi <= w_neg_a;
                            if (!op[1]) begin
                                r_state <= ST_MUL;
                                r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                                r_mcand <= w_mag_a;
                            end else if (opb == '0) begin
                                // Raw dividend is parked for the HI result.
                                r_state <= ST_DIV0;
                                r_acc   <= {{WIDTH{1'b0}}, opa};
                                r_mcand <= '0;
                            end else begin
                                r_state <= ST_DIV;
                                r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                                r_mcand <= w_mag_b;
                            end
                        end
                    end
                    ST_MUL: begin
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(MUL_STEPS - 1)) r_state <= ST_FIX;
                    end
                    ST_DIV: begin
                        r_rem <= w_div_rem;
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_q};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(DIV_STEPS - 1)) r_state <= ST_FIX;
                    end
                    ST_DIV0: begin
                        r_hi    <= r_acc[WIDTH-1:0];
                        r_lo    <= '1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    ST_FIX: begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_iterative #(
        .WIDTH   (32),
        .MUL_BPC (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .cancel (cancel),
        .hi_wen (hi_wen),
        .lo_wen (lo_wen),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     sa, sb;
        case (o)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                sa = a;
                sb = b;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [31:0] b);
        if (!o[1]) return 17;
        if (b == 32'd0) return 1;
        return 33;
    endfunction

    // Called at a negedge with the unit idle; drives start in cycle 0 and
    // checks busy/done every cycle through one cycle past done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input bit second_start);
        logic [63:0] e;
        int          n;
        e = model(o, a, b);
        n = latency(o, b);
        op = o; opa = a; opb = b; start = 1'b1;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c <= n) begin
                chk("busy_in_flight", busy, 1);
                chk("no_early_done", done, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
                chk("hi_result", hi, e[63:32]);
                chk("lo_result", lo, e[31:0]);
            end
            start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
            if (noise && c < n) begin
                start  = 1'($urandom_range(0, 1));
                op     = 2'($urandom_range(0, 3));
                opa    = $urandom;
                opb    = $urandom;
                hi_wen = 1'($urandom_range(0, 1));
                lo_wen = 1'($urandom_range(0, 1));
                wdata  = $urandom;
            end
            if (second_start && c == 1) start = 1'b1;
        end
        @(negedge clk);
        chk("done_once", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, lo_saved;
        int          seen;

        rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
        op = 2'd0; opa = '0; opb = '0; wdata = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Directed results
        run_op(2'd0, 32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b0);
        chk("mult_hi_const", hi, 32'hFFFFFFFF);
        chk("mult_lo_const", lo, 32'hFFFFFFEB);
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("multu_hi_const", hi, 32'hFFFFFFFE);
        chk("multu_lo_const", lo, 32'h00000001);
        run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
        chk("div_lo_const", lo, 32'hFFFFFFFD);
        chk("div_hi_const", hi, 32'hFFFFFFFF);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("divmin_lo_const", lo, 32'h80000000);
        chk("divmin_hi_const", hi, 32'h00000000);
        run_op(2'd3, 32'h00001234, 32'h00000000, 1'b0, 1'b1);
        chk("div0_lo_const", lo, 32'hFFFFFFFF);
        chk("div0_hi_const", hi, 32'h00001234);
        run_op(2'd2, 32'h80000001, 32'h00000000, 1'b1, 1'b0);

        // Randomized operations with ignored start/write noise while busy
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(ro, ra, rb, 1'b1, 1'b0);
        end

        // MTHI preload then cancel a DIV in cycle 5
        hi_wen = 1'b1; wdata = 32'hAAAA0000;
        @(negedge clk);
        hi_wen = 1'b0;
        chk("mthi_preload", hi, 32'hAAAA0000);
        lo_saved = lo;
        op = 2'd2; opa = 32'h12345678; opb = 32'h00000007; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_before_cancel", busy, 1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("cancel_no_done", seen, 0);
        chk("cancel_hi_kept", hi, 32'hAAAA0000);
        chk("cancel_lo_kept", lo, lo_saved);

        // cancel and start together in idle: start dropped
        op = 2'd1; opa = 32'd9; opb = 32'd9; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_start_busy", busy, 0);
        @(negedge clk);
        chk("cancel_start_done", done, 0);
        chk("cancel_start_hi", hi, 32'hAAAA0000);

        // Write and start in the same cycle: write applied, then overwritten
        op = 2'd1; opa = 32'd5; opb = 32'd6; start = 1'b1; hi_wen = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        start = 1'b0; hi_wen = 1'b0;
        chk("wr_start_hi", hi, 32'h12345678);
        chk("wr_start_busy", busy, 1);
        for (int c = 2; c <= 18; c++) @(negedge clk);
        chk("wr_start_done", done, 1);
        chk("wr_start_res_hi", hi, 32'h00000000);
        chk("wr_start_res_lo", lo, 32'h0000001E);

        // MULT 3*4 with MTLO in the done cycle
        @(negedge clk);
        op = 2'd0; opa = 32'd3; opb = 32'd4; start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mtlo_done", done, 1);
        chk("mtlo_lo_result", lo, 32'h0000000C);
        lo_wen = 1'b1; wdata = 32'h00000005;
        @(negedge clk);
        lo_wen = 1'b0;
        chk("mtlo_lo_written", lo, 32'h00000005);
        chk("mtlo_hi_result", hi, 32'h00000000);

        // Asynchronous reset in cycle 10 of a MUL
        op = 2'd1; opa = 32'hDEADBEEF; opb = 32'h00000003; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'd0, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
